regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have ports: Clk, input, 1, rising-edge clock.
REQ-003 SHALL have ports: Reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports: Stall, input, 1, hold output stage and refuse new writes.
REQ-005 SHALL have ports: ReqA, input, 1, ALU writeback request valid.
REQ-006 SHALL have ports: AddrA, input, 5, ALU destination register.
REQ-007 SHALL have ports: DataA, input, 32, ALU write data.
REQ-008 SHALL have ports: AckA, output, 1, ALU request accepted this cycle.
REQ-009 SHALL have ports: ReqB, input, 1, memory/load writeback request valid.
REQ-010 SHALL have ports: AddrB, input, 5, load destination register.
REQ-011 SHALL have ports: DataB, input, 32, load write data.
REQ-012 SHALL have ports: AckB, output, 1, load request accepted this cycle.
REQ-013 SHALL have ports: WE, output, 32, registered one-hot register-file write enable.
REQ-014 SHALL have ports: WD, output, 32, registered register-file write data.
REQ-015 SHALL have ports: Conflict, output, 1, registered; both requesters valid in the previous accept cycle.

Function
REQ-016 SHALL make AckA/AckB combinational: at most one high per cycle, both low while Stall=1 or Reset=1.
REQ-017 SHALL, with exactly one request valid and Stall=0, acknowledge that requester.
REQ-018 SHALL, with both valid and Stall=0, grant the requester indicated by round-robin pointer Prio (0=A, 1=B), then set Prio to the other requester.
REQ-019 SHALL leave Prio unchanged when a grant is uncontested.
REQ-020 SHALL, on the edge after an Ack, load WE with the one-hot decode of the granted address and WD with the granted data (latency 1 cycle).
REQ-021 SHALL drive WE to all-zero on the edge after any cycle with no Ack and Stall=0 (each write pulses exactly one cycle).
REQ-022 SHALL hold WE, WD and Conflict unchanged while Stall=1.
REQ-023 SHALL implement a two-state FSM: IDLE (WE=0) and WRITE (WE one-hot); IDLE->WRITE on Ack, WRITE->WRITE on Ack, WRITE->IDLE on no Ack with Stall=0, no transition while Stall=1.
REQ-024 SHALL treat a non-acknowledged requester as required to hold Req/Addr/Data stable; the block does not buffer it.
REQ-025 SHALL give address 0 write treatment per REQ-032/REQ-033, still acknowledging the request.
REQ-026 SHALL permit identical AddrA/AddrB in the same cycle; only the granted one writes that cycle.

Reset
REQ-027 SHALL on Reset set WE=0, WD=0, Conflict=0, Prio=0 (A first), FSM=IDLE.
REQ-028 SHALL, when Reset rises mid-write, discard the pending write; no WE pulse follows reset.
REQ-029 SHALL give Reset priority over Stall and requests.

Configuration
REQ-030 SHALL use macro RFARB_R0_WRITE_EN.
REQ-031 SHALL, when defined, let address 0 produce WE[0]=1 like any other register.
REQ-032 SHALL, when undefined (default), force WE=0 for address-0 grants (FSM still enters WRITE, WD still loads).
REQ-033 SHALL make Ack behaviour identical in both builds.

Structure
REQ-034 SHALL place in shared package rfarb_pkg: constants REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32; typedef for FSM state {IDLE, WRITE}.
REQ-035 SHALL instantiate sub-module decoder_5_32 for the address-to-one-hot decode; gating and registering are done in this block.

Verification
REQ-036 SHALL verify: ReqA=1 AddrA=5 DataA=0x1234 alone -> AckA=1 same cycle; next cycle WE=0x00000020, WD=0x1234; following idle cycle WE=0.
REQ-037 SHALL verify: ReqA,ReqB both held 4 cycles, AddrA=3, AddrB=7, from reset -> grants A,B,A,B; WE sequence 0x8,0x80,0x8,0x80; Conflict=1.
REQ-038 SHALL verify: Stall=1 for 3 cycles during WRITE with WE=0x400 -> WE/WD held, AckA=AckB=0; after release pending ReqB acknowledged.
REQ-039 SHALL verify: ReqB AddrB=0 DataB=0xFFFFFFFF -> AckB=1; WE=0 next cycle without macro, WE=0x1 with RFARB_R0_WRITE_EN.
REQ-040 SHALL verify: Reset asserted the cycle after AckA for AddrA=31 -> next edge WE=0, WD=0, Prio=0; no WE[31] pulse.
REQ-041 SHALL verify: one-hot property each cycle -> popcount(WE) <= 1 and at most one Ack, under 1000 random cycles.

Source files
------------

// File: rtl/rfarb_pkg.sv
// Shared constants and FSM state type for the register-file write arbiter.
// Imported by the interface, the decoder and the arbiter top.
package rfarb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the two writeback requesters and the arbiter.
// Stall, ReqA/AddrA/DataA/AckA, ReqB/AddrB/DataB/AckB, WE/WD/Conflict.
interface regfile_write_arbiter_if;
    import rfarb_pkg::*;

    logic                  Stall;
    logic                  ReqA;
    logic [REG_ADDR_W-1:0] AddrA;
    logic [REG_DATA_W-1:0] DataA;
    logic                  AckA;
    logic                  ReqB;
    logic [REG_ADDR_W-1:0] AddrB;
    logic [REG_DATA_W-1:0] DataB;
    logic                  AckB;
    logic [NUM_REGS-1:0]   WE;
    logic [REG_DATA_W-1:0] WD;
    logic                  Conflict;

    modport master (
        output Stall, ReqA, AddrA, DataA,
        output ReqB, AddrB, DataB,
        input  AckA, AckB, WE, WD, Conflict
    );

    modport slave (
        input  Stall, ReqA, AddrA, DataA,
        input  ReqB, AddrB, DataB,
        output AckA, AckB, WE, WD, Conflict
    );

endinterface

// File: rtl/regfile_write_arbiter_decoder_5_32.sv
// decoder_5_32: register address to one-hot write-enable decode.
// Ports: addr (5b in), onehot (32b out).
module decoder_5_32
    import rfarb_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr,
    output logic [NUM_REGS-1:0]   onehot
);

    always_comb begin
        onehot       = '0;
        onehot[addr] = 1'b1;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester (ALU / load) register-file write arbiter, round-robin on
// contention, registered one-hot WE/WD with 1-cycle latency.
// Ports: Clk, Reset (sync, active-high), bus (regfile_write_arbiter_if.slave).
// Build option RFARB_R0_WRITE_EN: when defined, address 0 produces WE[0];
// by default writes to address 0 are acknowledged but never enabled.
module regfile_write_arbiter
    import rfarb_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Reset,
    regfile_write_arbiter_if.slave  bus
);

    state_t                state;
    state_t                state_nxt;
    logic                  prio;
    logic                  acka;
    logic                  ackb;
    logic                  ack;
    logic                  both;
    logic [REG_ADDR_W-1:0] gaddr;
    logic [REG_DATA_W-1:0] gdata;
    logic [NUM_REGS-1:0]   dec;
    logic [NUM_REGS-1:0]   we_gated;
    logic [NUM_REGS-1:0]   we_nxt;
    logic [NUM_REGS-1:0]   we_q;
    logic [REG_DATA_W-1:0] wd_q;
    logic                  cf_q;

    assign both  = bus.ReqA & bus.ReqB;
    assign ack   = acka | ackb;
    assign gaddr = ackb ? bus.AddrB : bus.AddrA;
    assign gdata = ackb ? bus.DataB : bus.DataA;

    decoder_5_32 u_dec (
        .addr   (gaddr),
        .onehot (dec)
    );

    always_comb begin
`ifdef RFARB_R0_WRITE_EN
        we_gated = dec;
`else
        we_gated = (gaddr == '0) ? '0 : dec;
`endif
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else if (!bus.Stall)
            state <= state_nxt;
    end

    // Next-state logic; stall is handled by the register hold
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = ack ? WRITE : IDLE;
            WRITE:   state_nxt = ack ? WRITE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: grants and the next WE value
    always_comb begin
        acka = 1'b0;
        ackb = 1'b0;
        if (!Reset && !bus.Stall) begin
            unique case ({bus.ReqA, bus.ReqB})
                2'b10: acka = 1'b1;
                2'b01: ackb = 1'b1;
                2'b11: begin
                    acka = ~prio;
                    ackb = prio;
                end
                default: ;
            endcase
        end
        we_nxt = (state_nxt == WRITE) ? we_gated : '0;
    end

    // Datapath registers; WD and Conflict only move on an accept
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prio <= 1'b0;
            we_q <= '0;
            wd_q <= '0;
            cf_q <= 1'b0;
        end else if (!bus.Stall) begin
            we_q <= we_nxt;
            if (ack) begin
                wd_q <= gdata;
                cf_q <= both;
            end
            if (both)
                prio <= ~prio;
        end
    end

    assign bus.AckA     = acka;
    assign bus.AckB     = ackb;
    assign bus.WE       = we_q;
    assign bus.WD       = wd_q;
    assign bus.Conflict = cf_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed vectors push
// expectations, a negedge monitor pops and compares; then a random sweep.
module tb_regfile_write_arbiter;

    logic clk;
    logic rst;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RFARB_R0_WRITE_EN
    localparam logic [31:0] R0WE = 32'h1;
`else
    localparam logic [31:0] R0WE = 32'h0;
`endif

    typedef struct {
        string       nm;
        logic        a;
        logic        b;
        bit          cwe;
        logic [31:0] we;
        bit          cwd;
        logic [31:0] wd;
        bit          ccf;
        logic        cf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rnd    = 0;

    // Monitor: sample mid-cycle, away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (bus.AckA !== e.a || bus.AckB !== e.b) begin
                errors++;
                $display("FAIL %s ack: got A=%b B=%b exp A=%b B=%b",
                         e.nm, bus.AckA, bus.AckB, e.a, e.b);
            end
            if (e.cwe) begin
                checks++;
                if (bus.WE !== e.we) begin
                    errors++;
                    $display("FAIL %s WE: got %h exp %h",
                             e.nm, bus.WE, e.we);
                end
            end
            if (e.cwd) begin
                checks++;
                if (bus.WD !== e.wd) begin
                    errors++;
                    $display("FAIL %s WD: got %h exp %h",
                             e.nm, bus.WD, e.wd);
                end
            end
            if (e.ccf) begin
                checks++;
                if (bus.Conflict !== e.cf) begin
                    errors++;
                    $display("FAIL %s Conflict: got %b exp %b",
                             e.nm, bus.Conflict, e.cf);
                end
            end
        end
        if (rnd) begin
            checks++;
            if ($countones(bus.WE) > 1 || (bus.AckA && bus.AckB) ||
                ((bus.Stall || rst) && (bus.AckA || bus.AckB))) begin
                errors++;
                $display("FAIL onehot: WE=%h AckA=%b AckB=%b Stall=%b Reset=%b",
                         bus.WE, bus.AckA, bus.AckB, bus.Stall, rst);
            end
        end
    end

    task automatic step(
        input string       nm,
        input bit          rs,
        input bit          st,
        input bit          ra,
        input logic [4:0]  aa,
        input logic [31:0] da,
        input bit          rb,
        input logic [4:0]  ab,
        input logic [31:0] db,
        input bit          ea,
        input bit          eb,
        input bit          cwe,
        input logic [31:0] we,
        input bit          cwd,
        input logic [31:0] wd,
        input bit          ccf,
        input bit          cf
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst       = rs;
        bus.Stall = st;
        bus.ReqA  = ra;
        bus.AddrA = aa;
        bus.DataA = da;
        bus.ReqB  = rb;
        bus.AddrB = ab;
        bus.DataB = db;
        e.nm  = nm;
        e.a   = ea;
        e.b   = eb;
        e.cwe = cwe;
        e.we  = we;
        e.cwd = cwd;
        e.wd  = wd;
        e.ccf = ccf;
        e.cf  = cf;
        q.push_back(e);
    endtask

    initial begin
        rst       = 1'b1;
        bus.Stall = 1'b0;
        bus.ReqA  = 1'b0;
        bus.AddrA = '0;
        bus.DataA = '0;
        bus.ReqB  = 1'b0;
        bus.AddrB = '0;
        bus.DataB = '0;

        // reset: acks low even with requests valid, then cleared outputs
        step("rst0", 1, 0, 1, 5, 1, 1, 6, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0);

        // single ALU write to r5
        step("a5",    0, 0, 1, 5, 32'h1234, 0, 0, 0,
             1, 0, 1, 0, 1, 0, 1, 0);
        step("a5wr",  0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 1, 32'h20, 1, 32'h1234, 1, 0);
        step("a5end", 0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 1, 0, 0, 0, 0, 0);

        // contested: A3 vs B7 for 4 cycles
        step("rr1", 0, 0, 1, 3, 32'hA3, 1, 7, 32'hB7,
             1, 0, 1, 0, 0, 0, 0, 0);
        step("rr2", 0, 0, 1, 3, 32'hA3, 1, 7, 32'hB7,
             0, 1, 1, 32'h8, 1, 32'hA3, 1, 1);
        step("rr3", 0, 0, 1, 3, 32'hA3, 1, 7, 32'hB7,
             1, 0, 1, 32'h80, 1, 32'hB7, 1, 1);
        step("rr4", 0, 0, 1, 3, 32'hA3, 1, 7, 32'hB7,
             0, 1, 1, 32'h8, 1, 32'hA3, 1, 1);
        step("rr5", 0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 1, 32'h80, 1, 32'hB7, 1, 1);
        step("rr6", 0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 1, 0, 0, 0, 1, 1);

        // uncontested grant must not move the pointer
        step("ub1", 0, 0, 0, 0, 0, 1, 9, 32'h99,
             0, 1, 1, 0, 0, 0, 0, 0);
        step("ub2", 0, 0, 1, 1, 32'h11, 1, 2, 32'h22,
             1, 0, 1, 32'h200, 1, 32'h99, 1, 0);
        step("ub3", 0, 0, 0, 0, 0, 1, 2, 32'h22,
             0, 1, 1, 32'h2, 1, 32'h11, 1, 1);
        step("ub4", 0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 1, 32'h4, 1, 32'h22, 1, 0);
        step("ub5", 0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 1, 0, 0, 0, 0, 0);

        // stall for 3 cycles while WE=0x400, pending load write
        step("st1", 0, 0, 1, 10, 32'hAAAA, 0, 0, 0,
             1, 0, 1, 0, 0, 0, 1, 0);
        step("st2", 0, 1, 0, 0, 0, 1, 4, 32'h4444,
             0, 0, 1, 32'h400, 1, 32'hAAAA, 1, 0);
        step("st3", 0, 1, 0, 0, 0, 1, 4, 32'h4444,
             0, 0, 1, 32'h400, 1, 32'hAAAA, 1, 0);
        step("st4", 0, 1, 0, 0, 0, 1, 4, 32'h4444,
             0, 0, 1, 32'h400, 1, 32'hAAAA, 1, 0);
        step("st5", 0, 0, 0, 0, 0, 1, 4, 32'h4444,
             0, 1, 1, 32'h400, 1, 32'hAAAA, 1, 0);
        step("st6", 0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 1, 32'h10, 1, 32'h4444, 1, 0);
        step("st7", 0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 1, 0, 0, 0, 0, 0);

        // load to r0
        step("r0a", 0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF,
             0, 1, 1, 0, 0, 0, 0, 0);
        step("r0b", 0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 1, R0WE, 1, 32'hFFFFFFFF, 1, 0);
        step("r0c", 0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 1, 0, 0, 0, 0, 0);

        // reset right after an r31 grant; pointer was B before it
        step("rs1", 0, 0, 1, 31, 32'h31, 0, 0, 0,
             1, 0, 1, 0, 0, 0, 0, 0);
        step("rs2", 1, 1, 1, 31, 32'h31, 1, 5, 32'h5,
             0, 0, 0, 0, 0, 0, 0, 0);
        step("rs3", 0, 0, 1, 1, 32'h1, 1, 2, 32'h2,
             1, 0, 1, 0, 1, 0, 1, 0);
        step("rs4", 0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 1, 32'h2, 1, 32'h1, 1, 1);
        step("rs5", 0, 0, 0, 0, 0, 0, 0, 0,
             0, 0, 1, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, exp 0", q.size());
            q.delete();
        end

        // random sweep for the one-hot / single-grant properties
        @(posedge clk);
        #1;
        rnd = 1;
        for (int i = 0; i < 1000; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            bus.Stall = ($urandom_range(0, 4) == 0);
            bus.ReqA  = $urandom_range(0, 1);
            bus.ReqB  = $urandom_range(0, 1);
            bus.AddrA = 5'($urandom_range(0, 31));
            bus.AddrB = 5'($urandom_range(0, 31));
            bus.DataA = $urandom;
            bus.DataB = $urandom;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        rnd = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
